// File: rtl/mc_control_fsm_pkg.sv
// Shared definitions for the MulCPU multi-cycle control unit: state encodings,
// opcodes, datapath select codes and the control-line bundle.
package mc_control_fsm_pkg;

  typedef enum logic [3:0] {
    sIF     = 4'b0000,
    sID     = 4'b0001,
    sEXE_LS = 4'b0010,
    sMEM    = 4'b0011,
    sWB_LD  = 4'b0100,
    sEXE_BR = 4'b0101,
    sEXE_AL = 4'b0110,
    sWB_AL  = 4'b0111,
    sHALT   = 4'b1000
  } state_e;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_RS     = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  localparam logic [1:0] RO_RA = 2'b00;
  localparam logic [1:0] RO_RT = 2'b01;
  localparam logic [1:0] RO_RD = 2'b10;

  typedef enum logic [3:0] {
    OC_RTYPE, OC_ITYPE, OC_STORE, OC_LOAD, OC_BEQ,
    OC_JMP, OC_JR, OC_JAL, OC_HALT, OC_NOP
  } op_class_e;

  typedef struct packed {
    logic       pc_wre;
    logic       ir_wre;
    logic       ins_mem_rw;
    logic       reg_wre;
    logic [1:0] reg_out;
    logic       wr_reg_d_src;
    logic       db_data_src;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [2:0] alu_op;
    logic       ext_sel;
    logic       m_rd;
    logic       m_wr;
    logic [1:0] pc_src;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    pc_wre: 1'b0, ir_wre: 1'b0, ins_mem_rw: 1'b1, reg_wre: 1'b0,
    reg_out: RO_RT, wr_reg_d_src: 1'b0, db_data_src: 1'b0,
    alu_src_a: 1'b0, alu_src_b: 1'b0, alu_op: ALU_ADD, ext_sel: 1'b0,
    m_rd: 1'b0, m_wr: 1'b0, pc_src: PC_NEXT
  };

  // HALT_OP is checked first so a reassigned halt opcode always wins.
  function automatic op_class_e op_class(input logic [5:0] op, input logic [5:0] halt_op);
    if (op == halt_op) return OC_HALT;
    case (op)
      OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLL, OP_SLT: return OC_RTYPE;
      OP_ADDI, OP_ORI: return OC_ITYPE;
      OP_SW:  return OC_STORE;
      OP_LW:  return OC_LOAD;
      OP_BEQ: return OC_BEQ;
      OP_J:   return OC_JMP;
      OP_JR:  return OC_JR;
      OP_JAL: return OC_JAL;
      default: return OC_NOP;
    endcase
  endfunction

  function automatic logic [2:0] alu_op_of(input logic [5:0] op);
    case (op)
      OP_SUB:         return ALU_SUB;
      OP_OR, OP_ORI:  return ALU_OR;
      OP_AND:         return ALU_AND;
      OP_SLL:         return ALU_SLL;
      OP_SLT:         return ALU_SLT;
      default:        return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational decode of (state, opcode, zero) into the datapath control bundle.
module mc_ctrl_decode
  import mc_control_fsm_pkg::*;
#(
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  state_e     state_i,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  output ctrl_t      ctrl_o
);

  op_class_e cls;

  always_comb begin
    cls    = op_class(opcode_i, HALT_OP);
    ctrl_o = CTRL_IDLE;
    case (state_i)
      sIF: ctrl_o.ir_wre = 1'b1;
      sID: begin
        case (cls)
          OC_JMP: begin
            ctrl_o.pc_wre = 1'b1;
            ctrl_o.pc_src = PC_JUMP;
          end
          OC_JR: begin
            ctrl_o.pc_wre = 1'b1;
            ctrl_o.pc_src = PC_RS;
          end
          OC_JAL: begin
            ctrl_o.pc_wre       = 1'b1;
            ctrl_o.pc_src       = PC_JUMP;
            ctrl_o.reg_wre      = 1'b1;
            ctrl_o.reg_out      = RO_RA;
            ctrl_o.wr_reg_d_src = 1'b0;
          end
          OC_NOP: begin
            ctrl_o.pc_wre = 1'b1;
            ctrl_o.pc_src = PC_NEXT;
          end
          default: ;
        endcase
      end
      sEXE_AL: begin
        ctrl_o.alu_op    = alu_op_of(opcode_i);
        ctrl_o.alu_src_a = (opcode_i == OP_SLL);
        ctrl_o.alu_src_b = (cls == OC_ITYPE);
        ctrl_o.ext_sel   = (opcode_i == OP_ADDI);
      end
      sWB_AL: begin
        ctrl_o.reg_wre      = 1'b1;
        ctrl_o.wr_reg_d_src = 1'b1;
        ctrl_o.db_data_src  = 1'b0;
        ctrl_o.reg_out      = (cls == OC_RTYPE) ? RO_RD : RO_RT;
        ctrl_o.pc_wre       = 1'b1;
        ctrl_o.pc_src       = PC_NEXT;
      end
      sEXE_LS: begin
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.alu_src_b = 1'b1;
        ctrl_o.ext_sel   = 1'b1;
      end
      sMEM: begin
        if (cls == OC_LOAD) begin
          ctrl_o.m_rd = 1'b1;
        end else begin
          ctrl_o.m_wr   = 1'b1;
          ctrl_o.pc_wre = 1'b1;
          ctrl_o.pc_src = PC_NEXT;
        end
      end
      sWB_LD: begin
        ctrl_o.reg_wre      = 1'b1;
        ctrl_o.reg_out      = RO_RT;
        ctrl_o.wr_reg_d_src = 1'b1;
        ctrl_o.db_data_src  = 1'b1;
        ctrl_o.pc_wre       = 1'b1;
        ctrl_o.pc_src       = PC_NEXT;
      end
      sEXE_BR: begin
        ctrl_o.alu_op  = ALU_SUB;
        ctrl_o.ext_sel = 1'b1;
        ctrl_o.pc_wre  = 1'b1;
        ctrl_o.pc_src  = zero_i ? PC_BRANCH : PC_NEXT;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// MulCPU multi-cycle control unit: state register, next-state logic and
// reset gating around the control decode.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       sign,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       RegWre,
  output logic [1:0] RegOut,
  output logic       WrRegDSrc,
  output logic       DBDataSrc,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       ExtSel,
  output logic       mRD,
  output logic       mWR,
  output logic [1:0] PCSrc,
  output logic [3:0] state
);

  state_e    state_q, state_d;
  op_class_e cls;
  ctrl_t     ctrl_dec, ctrl;
  logic      unused_sign;

  assign unused_sign = sign;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state_q <= sIF;
    else       state_q <= state_d;
  end

  always_comb begin
    cls     = op_class(opcode, HALT_OP);
    state_d = state_q;
    case (state_q)
      sIF: state_d = sID;
      sID: begin
        case (cls)
          OC_RTYPE, OC_ITYPE: state_d = sEXE_AL;
          OC_STORE, OC_LOAD:  state_d = sEXE_LS;
          OC_BEQ:             state_d = sEXE_BR;
          OC_HALT:            state_d = sHALT;
          default:            state_d = sIF;
        endcase
      end
      sEXE_AL: state_d = sWB_AL;
      sEXE_LS: state_d = sMEM;
      sMEM:    state_d = (cls == OC_LOAD) ? sWB_LD : sIF;
      sHALT:   state_d = sHALT;
      default: state_d = sIF;
    endcase
  end

  mc_ctrl_decode #(.HALT_OP(HALT_OP)) u_decode (
    .state_i  (state_q),
    .opcode_i (opcode),
    .zero_i   (zero),
    .ctrl_o   (ctrl_dec)
  );

  // sIF decodes IRWre=1, so Reset must override the decode rather than rely on the state.
  always_comb begin
    ctrl = ctrl_dec;
    if (Reset) ctrl = CTRL_IDLE;
  end

  assign PCWre     = ctrl.pc_wre;
  assign IRWre     = ctrl.ir_wre;
  assign InsMemRW  = ctrl.ins_mem_rw;
  assign RegWre    = ctrl.reg_wre;
  assign RegOut    = ctrl.reg_out;
  assign WrRegDSrc = ctrl.wr_reg_d_src;
  assign DBDataSrc = ctrl.db_data_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ALUOp     = ctrl.alu_op;
  assign ExtSel    = ctrl.ext_sel;
  assign mRD       = ctrl.m_rd;
  assign mWR       = ctrl.m_wr;
  assign PCSrc     = ctrl.pc_src;
  assign state     = state_q;

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle control unit for the MulCPU datapath. It sequences every instruction through the IF / ID / EXE / MEM / WB states and drives all datapath control lines, including the 2-bit `RegOut` select for the write-register mux and the register-file write enable. It sits between the instruction register (it takes the opcode from there) and the ALU zero/sign flags (it takes those back from the ALU).

## Interface
Parameters:
- `HALT_OP`, default 6'b111111: opcode that stops the machine.

Ports:
- `CLK` in 1: system clock; all state updates on the rising edge.
- `Reset` in 1: asynchronous, active-high; forces state to sIF.
- `opcode` in 6: IR[31:26]; stable from ID onward.
- `zero` in 1: ALU result == 0.
- `sign` in 1: ALU result MSB; reserved, no effect in this release.
- `PCWre` out 1: PC load enable.
- `IRWre` out 1: IR load enable.
- `InsMemRW` out 1: instruction memory read (1 = read).
- `RegWre` out 1: register-file write enable.
- `RegOut` out 2: write-register select. 00 = $31, 01 = rt, 10 = rd, 11 = $24 (reserved, never driven).
- `WrRegDSrc` out 1: write data source. 0 = PC+4, 1 = DB bus.
- `DBDataSrc` out 1: DB source. 0 = ALU result, 1 = data memory.
- `ALUSrcA` out 1: 1 = shamt, 0 = rs.
- `ALUSrcB` out 1: 1 = extended immediate, 0 = rt.
- `ALUOp` out 3: 000 add, 001 sub, 010 or, 011 and, 100 sll, 101 slt.
- `ExtSel` out 1: 1 = sign-extend, 0 = zero-extend.
- `mRD` out 1: data memory read.
- `mWR` out 1: data memory write.
- `PCSrc` out 2: 00 = PC+4, 01 = branch target, 10 = rs (jr), 11 = jump target.
- `state` out 4: current state, for debug and the bench.

## Operation
- Opcodes:
  - R-type ALU: add 000000, sub 000001, or 010000, and 010001, sll 011000, slt 100110.
  - I-type: addi 000010, ori 010010.
  - Memory: sw 110000, lw 110001.
  - Control flow: beq 110100, j 111000, jr 111001, jal 111010, halt = `HALT_OP`.
- State transitions:
  - sIF → sID always.
  - From sID:
    - R-type ALU and I-type → sEXE_AL.
    - sw, lw → sEXE_LS.
    - beq → sEXE_BR.
    - j, jr, jal, and unknown opcodes → sIF.
    - halt → sHALT.
  - sEXE_AL → sWB_AL.
  - sEXE_LS → sMEM.
  - sMEM → sWB_LD for lw; sMEM → sIF for sw.
  - sEXE_BR, sWB_AL, sWB_LD → sIF.
  - sHALT → sHALT until `Reset` is asserted.
- Outputs are a pure function of the registered state and `opcode` (plus `zero` in sEXE_BR).
- Any control line not listed for a state below is 0, except `RegOut`, which defaults to 01, and `InsMemRW`, which is 1 in all states.
- Per-state assertions:
  - sIF: `IRWre` = 1.
  - sID, j: `PCWre` = 1, `PCSrc` = 11.
  - sID, jr: `PCWre` = 1, `PCSrc` = 10.
  - sID, jal: `PCWre` = 1, `PCSrc` = 11, `RegWre` = 1, `RegOut` = 00, `WrRegDSrc` = 0.
  - sID, unknown opcode: `PCWre` = 1, `PCSrc` = 00 (treated as a nop).
  - sEXE_AL: `ALUOp` per opcode; `ALUSrcB` = 1 for addi/ori; `ALUSrcA` = 1 for sll; `ExtSel` = 1 for addi, 0 for ori.
  - sWB_AL: `RegWre` = 1, `WrRegDSrc` = 1, `DBDataSrc` = 0, `RegOut` = 10 for R-type and 01 for I-type, `PCWre` = 1, `PCSrc` = 00.
  - sEXE_LS: `ALUOp` = add, `ALUSrcB` = 1, `ExtSel` = 1.
  - sMEM: `mRD` = 1 for lw; `mWR` = 1 for sw. For sw only, also `PCWre` = 1 and `PCSrc` = 00.
  - sWB_LD: `RegWre` = 1, `RegOut` = 01, `WrRegDSrc` = 1, `DBDataSrc` = 1, `PCWre` = 1, `PCSrc` = 00.
  - sEXE_BR: `ALUOp` = sub, `ExtSel` = 1, `PCWre` = 1, `PCSrc` = 01 if `zero` else 00.
  - sHALT: `PCWre` = 0, `IRWre` = 0, all other enables 0.

## Timing
- Latency in cycles, IF through the PC update:
  - j, jr, jal: 2.
  - beq: 3.
  - R-type, I-type, sw: 4.
  - lw: 5.
- `PCWre` is high for exactly one cycle per instruction, always in its final state. The next state is always sIF.
- Write enables (`RegWre`, `mWR`, `PCWre`, `IRWre`) take effect at the rising edge that ends the asserting state.
- While `Reset` is high:
  - `state` = sIF.
  - All write enables are forced to 0, including `IRWre`.
  - `RegOut` = 01, `InsMemRW` = 1, all other outputs 0.
- First fetch occurs on the first rising edge after `Reset` deasserts.
- `Reset` asserted mid-instruction: `state` returns to sIF immediately (asynchronous). No partial write occurs after assertion; writes already clocked in are not undone.
- `zero` is sampled only in sEXE_BR; it must be settled before the rising edge that ends that state.

## Structure
- Shared include `mc_defs.vh` holds:
  - the opcode constants;
  - the state encodings: sIF 0000, sID 0001, sEXE_LS 0010, sMEM 0011, sWB_LD 0100, sEXE_BR 0101, sEXE_AL 0110, sWB_AL 0111, sHALT 1000;
  - the `ALUOp`, `PCSrc`, and `RegOut` codes.
- The datapath mux and ALU also use `mc_defs.vh`.
- One sub-module, `mc_ctrl_decode`: combinational decode from (`state`, `opcode`, `zero`) to the output vector.
- The top level holds the state register and the next-state logic.

## Test plan
- Reset held 3 cycles, then released with `opcode` = add:
  - During reset: `state` = 0000, all enables 0.
  - After release: states 0000 → 0001 → 0110 → 0111 → 0000; `RegWre` = 1 and `RegOut` = 10 only in 0111.
- lw (110001): 5-cycle sequence; `mRD` = 1 in sMEM; sWB_LD drives `RegOut` = 01, `DBDataSrc` = 1, `RegWre` = 1; one `PCWre` pulse.
- beq:
  - With `zero` = 1: `PCSrc` = 01 in sEXE_BR.
  - With `zero` = 0: `PCSrc` = 00.
  - Both cases return to sIF after 3 cycles.
- jal (111010): in sID, `RegWre` = 1, `RegOut` = 00, `WrRegDSrc` = 0, `PCSrc` = 11; next state sIF.
- halt (111111): the machine stays in sHALT for 20 cycles with `PCWre` = `IRWre` = 0. `Reset` pulse → sIF.
- `Reset` asserted asynchronously in sMEM of sw: `mWR` drops the same cycle, `state` = 0000, no `PCWre` pulse.
